// File: rtl/pifdefs.sv
// pifdefs: shared address map and constants for the PIF register block.
// Holds write/read register addresses, read sub-addresses under R_ID,
// the ID byte, reset LED pattern and bus widths used by pifregs.
package pifdefs;

   // Bus widths (upper index of address fields, data width)
   localparam int unsigned TXA           = 3;
   localparam int unsigned TXSUBA        = 3;
   localparam int unsigned I2C_DATA_BITS = 6;

   // Register addresses decoded on XI_PRWA
   localparam logic [TXA:0] W_SCRATCH_REG = 4'h1;
   localparam logic [TXA:0] W_MISC_REG    = 4'h2;
   localparam logic [TXA:0] W_GP_IDX      = 4'h3;
   localparam logic [TXA:0] W_GP_DATA     = 4'h4;
   localparam logic [TXA:0] R_ID          = 4'h8;

   // Read sub-addresses under R_ID
   localparam logic [TXSUBA:0] R_ID_ID      = 4'd0;
   localparam logic [TXSUBA:0] R_ID_SCRATCH = 4'd1;
   localparam logic [TXSUBA:0] R_ID_MISC    = 4'd2;
   localparam logic [TXSUBA:0] R_ID_EVT     = 4'd3;
   localparam logic [TXSUBA:0] R_ID_GP_BASE = 4'd4;

   // Constant identification byte and misc reset pattern
   localparam logic [7:0] ID              = 8'hA5;
   localparam logic [1:0] LED_ALTERNATING = 2'b10;

endpackage

// File: rtl/pif_evt_sticky.sv
// pif_evt_sticky: per-bit sticky event latch with masked clear.
// Ports:
//   xclk     - clock
//   sys_rst  - asynchronous active-low reset
//   evt_in   - event pulses, one bit per event
//   clr_mask - bits to clear this cycle
//   sticky   - latched event bits
module pif_evt_sticky #(
   parameter int unsigned NUM_EVT = 4
) (
   input  logic               xclk,
   input  logic               sys_rst,
   input  logic [NUM_EVT-1:0] evt_in,
   input  logic [NUM_EVT-1:0] clr_mask,
   output logic [NUM_EVT-1:0] sticky
);

   // A new event in the clearing cycle survives: set has priority.
   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) sticky <= '0;
      else          sticky <= (sticky & ~clr_mask) | evt_in;
   end

endmodule

// File: rtl/pifregs.sv
// pifregs: PIF register block with scratch, misc, indexed GP registers,
// sticky events and a 4-stage registered readback pipeline.
// Ports:
//   xclk           - clock
//   sys_rst        - asynchronous active-low reset
//   XI_PWr         - write strobe
//   XI_PRWA        - read/write register address
//   XI_PRdFinished - end-of-read pulse (clears snapshotted events)
//   XI_PRdSubA     - read sub-address under R_ID
//   XI_PD          - write data
//   EvtIn          - event pulses
//   XO             - readback byte
//   MiscReg        - registered misc register
//   GpRegs         - flattened GP registers, GP[i] at [6i+5:6i]
//   EvtIrq         - registered OR of sticky events
module pifregs
   import pifdefs::*;
#(
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned NUM_EVT  = 4
) (
   input  logic                     xclk,
   input  logic                     sys_rst,
   input  logic                     XI_PWr,
   input  logic [TXA:0]             XI_PRWA,
   input  logic                     XI_PRdFinished,
   input  logic [TXSUBA:0]          XI_PRdSubA,
   input  logic [I2C_DATA_BITS-1:0] XI_PD,
   input  logic [NUM_EVT-1:0]       EvtIn,
   output logic [7:0]               XO,
   output logic [1:0]               MiscReg,
   output logic [NUM_REGS*6-1:0]    GpRegs,
   output logic                     EvtIrq
);

   localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [5:0]         scratch;
   logic [1:0]         misc;
   logic [5:0]         gp [NUM_REGS];
   logic [IDXW-1:0]    gp_idx;
   logic [NUM_EVT-1:0] sticky;
   logic [NUM_EVT-1:0] clr_mask;

   // Read pipeline state
   logic [TXSUBA:0]    sub1;
   logic               hit1;
   logic [5:0]         scratch1;
   logic [1:0]         misc1;
   logic [NUM_EVT-1:0] sticky1;
   logic [5:0]         gp1 [NUM_REGS];
   logic [7:0]         sel;
   logic [7:0]         byte2;
   logic               hit2;
   logic [7:0]         byte3;

   // Register writes
   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) begin
         scratch <= 6'h15;
         misc    <= LED_ALTERNATING;
         gp_idx  <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) gp[i] <= '0;
      end else if (XI_PWr) begin
         case (XI_PRWA)
            W_SCRATCH_REG: scratch <= XI_PD;
            W_MISC_REG:    misc    <= XI_PD[1:0];
            W_GP_IDX:      gp_idx  <= IDXW'(32'(XI_PD) % NUM_REGS);
            W_GP_DATA: begin
               gp[gp_idx] <= XI_PD;
               gp_idx     <= (gp_idx == IDXW'(NUM_REGS - 1)) ? '0 : gp_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Only events visible in the S1 snapshot are cleared, so an event that
   // arrives after the snapshot is not lost by the read that ends now.
   always_comb begin
      clr_mask = '0;
      if (XI_PRdFinished && (XI_PRWA == R_ID) && (XI_PRdSubA == R_ID_EVT))
         clr_mask = sticky1;
   end

   pif_evt_sticky #(.NUM_EVT(NUM_EVT)) u_sticky (
      .xclk     (xclk),
      .sys_rst  (sys_rst),
      .evt_in   (EvtIn),
      .clr_mask (clr_mask),
      .sticky   (sticky)
   );

   // S2 byte select from the S1 snapshot
   always_comb begin
      int unsigned sub_i;
      sub_i = 32'(sub1);
      sel   = {4'h6, sub1[3:0]};
      if (sub1 == R_ID_ID)           sel = ID;
      else if (sub1 == R_ID_SCRATCH) sel = {2'b01, scratch1};
      else if (sub1 == R_ID_MISC)    sel = {4'h5, 2'b00, misc1};
      else if (sub1 == R_ID_EVT)     sel = {2'b11, 6'(sticky1)};
      else if (sub_i >= 32'(R_ID_GP_BASE) && sub_i < 32'(R_ID_GP_BASE) + NUM_REGS)
         sel = {2'b10, gp1[IDXW'(sub_i - 32'(R_ID_GP_BASE))]};
   end

   // S1..S4 pipeline, plus the one-cycle output registers
   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) begin
         sub1     <= '0;
         hit1     <= 1'b0;
         scratch1 <= '0;
         misc1    <= '0;
         sticky1  <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) gp1[i] <= '0;
         byte2    <= '0;
         hit2     <= 1'b0;
         byte3    <= '0;
         XO       <= '0;
         MiscReg  <= '0;
         EvtIrq   <= 1'b0;
      end else begin
         sub1     <= XI_PRdSubA;
         hit1     <= (XI_PRWA == R_ID);
         scratch1 <= scratch;
         misc1    <= misc;
         sticky1  <= sticky;
         for (int unsigned i = 0; i < NUM_REGS; i++) gp1[i] <= gp[i];
         byte2    <= sel;
         hit2     <= hit1;
         byte3    <= hit2 ? byte2 : 8'h00;
         XO       <= byte3;
         MiscReg  <= misc;
         EvtIrq   <= |sticky;
      end
   end

   always_comb begin
      GpRegs = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) GpRegs[6*i +: 6] = gp[i];
   end

endmodule

// File: tb/tb_pifregs.sv
// tb_pifregs: directed self-checking bench for pifregs (NUM_REGS=4, NUM_EVT=4).
module tb_pifregs;
   import pifdefs::*;

   logic        xclk = 1'b0;
   logic        sys_rst;
   logic        XI_PWr;
   logic [3:0]  XI_PRWA;
   logic        XI_PRdFinished;
   logic [3:0]  XI_PRdSubA;
   logic [5:0]  XI_PD;
   logic [3:0]  EvtIn;
   logic [7:0]  XO;
   logic [1:0]  MiscReg;
   logic [23:0] GpRegs;
   logic        EvtIrq;

   int checks = 0;
   int errors = 0;

   pifregs #(.NUM_REGS(4), .NUM_EVT(4)) dut (
      .xclk           (xclk),
      .sys_rst        (sys_rst),
      .XI_PWr         (XI_PWr),
      .XI_PRWA        (XI_PRWA),
      .XI_PRdFinished (XI_PRdFinished),
      .XI_PRdSubA     (XI_PRdSubA),
      .XI_PD          (XI_PD),
      .EvtIn          (EvtIn),
      .XO             (XO),
      .MiscReg        (MiscReg),
      .GpRegs         (GpRegs),
      .EvtIrq         (EvtIrq)
   );

   always #5 xclk = ~xclk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge xclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] addr, input logic [5:0] data);
      XI_PWr  = 1'b1;
      XI_PRWA = addr;
      XI_PD   = data;
      tick(1);
      XI_PWr  = 1'b0;
   endtask

   task automatic rd(input logic [3:0] sub);
      XI_PRWA    = R_ID;
      XI_PRdSubA = sub;
      tick(4);
   endtask

   initial begin
      sys_rst        = 1'b0;
      XI_PWr         = 1'b0;
      XI_PRWA        = R_ID;
      XI_PRdFinished = 1'b0;
      XI_PRdSubA     = 4'd1;
      XI_PD          = '0;
      EvtIn          = 4'hF;   // pulses during reset must be lost
      tick(3);
      check("rst_xo", XO, 8'h00);
      check("rst_misc", MiscReg, 2'b00);
      check("rst_irq", EvtIrq, 1'b0);
      check("rst_gp", GpRegs, 24'h0);
      EvtIn   = 4'h0;
      sys_rst = 1'b1;

      // Reset release: read scratch, first valid XO on 4th edge
      tick(1);
      check("misc_after_rst", MiscReg, 2'b10);
      check("irq_after_rst", EvtIrq, 1'b0);
      tick(2);
      check("xo_cycle3", XO, 8'h00);
      tick(1);
      check("xo_cycle4_scratch", XO, 8'h55);

      rd(4'd0);
      check("rd_id", XO, 8'hA5);

      wr(W_SCRATCH_REG, 6'h2A);
      rd(4'd1);
      check("rd_scratch_wr", XO, 8'h6A);

      wr(W_MISC_REG, 6'h3D);
      check("miscreg_lag", MiscReg, 2'b10);
      tick(1);
      check("miscreg_new", MiscReg, 2'b01);
      rd(4'd2);
      check("rd_misc", XO, 8'h51);

      // GP index 7 mod 4 = 3, auto-increment wraps 3 -> 0 -> 1
      wr(W_GP_IDX, 6'h07);
      wr(W_GP_DATA, 6'h0A);
      wr(W_GP_DATA, 6'h0B);
      check("gp_regs", GpRegs, 24'h28000B);
      wr(W_GP_DATA, 6'h11);
      check("gp_idx_is1", GpRegs, 24'h28044B);
      rd(4'd7);
      check("rd_gp3", XO, 8'h8A);
      rd(4'd5);
      check("rd_gp1", XO, 8'h91);

      // Event 2 -> EvtIrq two edges later, readback, clear on read end
      XI_PRWA    = R_ID;
      XI_PRdSubA = 4'd3;
      EvtIn      = 4'b0100;
      tick(1);
      EvtIn      = 4'b0000;
      check("irq_lag1", EvtIrq, 1'b0);
      tick(1);
      check("irq_set", EvtIrq, 1'b1);
      tick(3);
      check("rd_evt", XO, 8'hC4);
      XI_PRdFinished = 1'b1;
      tick(1);
      XI_PRdFinished = 1'b0;
      check("irq_clear_lag", EvtIrq, 1'b1);
      tick(1);
      check("irq_cleared", EvtIrq, 1'b0);
      tick(4);
      check("rd_evt_cleared", XO, 8'hC0);

      // Set wins over clear in the same cycle
      EvtIn = 4'b0001;
      tick(1);
      EvtIn = 4'b0000;
      tick(4);
      check("rd_evt0", XO, 8'hC1);
      XI_PRdFinished = 1'b1;
      EvtIn          = 4'b0001;
      tick(1);
      XI_PRdFinished = 1'b0;
      EvtIn          = 4'b0000;
      tick(2);
      check("irq_set_wins", EvtIrq, 1'b1);
      tick(2);
      check("rd_evt0_kept", XO, 8'hC1);

      // Unmapped sub-addresses and GP range boundary
      rd(4'd12);
      check("rd_sub12", XO, 8'h6C);
      rd(4'd8);
      check("rd_sub8", XO, 8'h68);
      rd(4'd4);
      check("rd_gp0", XO, 8'h8B);

      // Non-R_ID address gates XO to zero
      XI_PRWA = W_SCRATCH_REG;
      tick(4);
      check("xo_not_rid", XO, 8'h00);

      // Reset mid-read
      rd(4'd1);
      check("rd_before_rst", XO, 8'h6A);
      XI_PRdSubA = 4'd1;
      tick(2);
      sys_rst = 1'b0;
      #1;
      check("xo_async_rst", XO, 8'h00);
      check("misc_async_rst", MiscReg, 2'b00);
      check("irq_async_rst", EvtIrq, 1'b0);
      tick(1);
      sys_rst = 1'b1;
      tick(3);
      check("xo_flushed", XO, 8'h00);
      tick(1);
      check("xo_after_rst", XO, 8'h55);
      check("gp_after_rst", GpRegs, 24'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pifregs.md
PIFREGS -- requirements
Module: pifregs

Interface
REQ-001 Parameter NUM_REGS, default 4, range 1..8: number of general-purpose (GP) registers.
REQ-002 Parameter NUM_EVT, default 4, range 1..6: number of sticky event inputs.
REQ-003 xclk  in  1  sole clock; all state on its rising edge.
REQ-004 sys_rst  in  1  reset, asynchronous, active-low.
REQ-005 XI_PWr  in  1  registered single-cycle write strobe.
REQ-006 XI_PRWA  in  `TXA+1  registered read/write register address.
REQ-007 XI_PRdFinished  in  1  single-cycle pulse, read cycle ended.
REQ-008 XI_PRdSubA  in  `TXSubA+1  read sub-address.
REQ-009 XI_PD  in  `I2C_DATA_BITS  write data (6 bits).
REQ-010 EvtIn  in  NUM_EVT  event pulses, synchronous to xclk.
REQ-011 XO  out  8  readback byte.
REQ-012 MiscReg  out  2  registered copy of misc register.
REQ-013 GpRegs  out  NUM_REGS*6  GP register contents, GP[i] at bits 6i+5..6i.
REQ-014 EvtIrq  out  1  registered OR of all sticky event bits.

Function
REQ-015 Writes occur only when XI_PWr=1; the decode is on XI_PRWA; unlisted addresses are ignored.
REQ-016 W_SCRATCH_REG loads Scratch<=XI_PD; W_MISC_REG loads Misc<=XI_PD[1:0].
REQ-017 W_GP_IDX loads GpIdx<=XI_PD mod NUM_REGS.
REQ-018 W_GP_DATA loads GP[GpIdx]<=XI_PD and sets GpIdx<=GpIdx+1, wrapping from NUM_REGS-1 to 0.
REQ-019 Each EvtIn[k]=1 sets Sticky[k] in the following cycle; the bit holds until cleared.
REQ-020 Clear-on-read: XI_PRdFinished=1 with XI_PRWA=R_ID and sub-address=R_ID_EVT clears the Sticky bits captured in the S1 snapshot.
REQ-021 Simultaneous EvtIn[k]=1 and a clear of bit k leaves Sticky[k]=1; set wins.
REQ-022 Read sub-address map under R_ID:
  - 0 -> `ID
  - 1 -> {2'b01, Scratch}
  - 2 -> {4'h5, 2'b00, Misc}
  - 3 -> {2'b11, zero-extended Sticky}
  - 4..4+NUM_REGS-1 -> {2'b10, GP[sub-4]}
  - all others -> {4'h6, sub[3:0]}
REQ-023 Read pipeline is 4 registered stages:
  - S1: registers sub-address and snapshot data.
  - S2: selects the byte.
  - S3: gates the byte with XI_PRWA==R_ID, otherwise 8'h00.
  - S4: drives XO.
REQ-024 XO reflects a stable XI_PRWA/XI_PRdSubA exactly 4 xclk cycles after they are sampled; XO is 8'h00 when XI_PRWA!=R_ID.
REQ-025 A write and a read pipeline access to the same register in the same cycle return the pre-write value; the new value is visible from the next S1 sample.
REQ-026 MiscReg and EvtIrq lag their sources by one cycle.

Reset
REQ-027 Asserting sys_rst low immediately forces:
  - Scratch=6'h15, Misc=`LED_ALTERNATING
  - GP[*]=0, GpIdx=0, Sticky=0
  - all pipeline stages=0
  - XO=8'h00, MiscReg=2'b00, EvtIrq=0
REQ-028 Reset asserted mid-read discards in-flight pipeline data; the first valid XO appears 4 cycles after reset release.
REQ-029 EvtIn pulses during reset are lost.

Structure
REQ-030 Shared package (pifdefs) holds the following; the module defines no local address literals:
  - addresses W_SCRATCH_REG, W_MISC_REG, W_GP_IDX, W_GP_DATA, R_ID
  - sub-addresses R_ID_ID, R_ID_SCRATCH, R_ID_MISC, R_ID_EVT, R_ID_GP_BASE
  - `ID, `LED_ALTERNATING, `TXA, `TXSubA, `I2C_DATA_BITS
REQ-031 Sticky set/clear logic is one sub-module, pif_evt_sticky, parameterised by NUM_EVT.

Verification
REQ-032 Reset release, read R_ID sub 1 -> XO=8'h55 on cycle 4; MiscReg=0 during reset, then `LED_ALTERNATING.
REQ-033 Write W_GP_IDX=3, then W_GP_DATA 6'h0A, 6'h0B with NUM_REGS=4 -> GP3=0A, GP0=0B, GpIdx=1; read sub 7 -> XO=8'h8A.
REQ-034 Pulse EvtIn[2] -> EvtIrq=1 two cycles later; read sub 3 -> XO=8'hC4; XI_PRdFinished -> Sticky=0, EvtIrq=0.
REQ-035 EvtIn[0] pulse in the same cycle as the clearing XI_PRdFinished -> Sticky[0] stays 1, EvtIrq stays 1.
REQ-036 Read sub 12 -> XO=8'h6C; XI_PRWA!=R_ID -> XO=8'h00; assert sys_rst mid-read -> XO=0 at once.
